// File: rtl/cdc_fifo_write_pointer_if.sv
// Write-side bundle of the CDC FIFO pointer engine: client request, RAM strobe, pointers and status flags.
// master = write client / environment, slave = cdc_fifo_write_pointer.
interface cdc_fifo_write_pointer_if #(
  parameter int unsigned ADDRESS_WIDTH = 4
);
  logic                     increment;
  logic                     clear_overflow;
  logic [ADDRESS_WIDTH:0]   read_pointer_gray;
  logic [ADDRESS_WIDTH-1:0] write_address;
  logic                     write_enable;
  logic [ADDRESS_WIDTH:0]   write_pointer_gray;
  logic [ADDRESS_WIDTH:0]   level;
  logic                     full;
  logic                     almost_full;
  logic                     overflow;

  modport master (
    output increment, clear_overflow, read_pointer_gray,
    input  write_address, write_enable, write_pointer_gray, level, full, almost_full, overflow
  );

  modport slave (
    input  increment, clear_overflow, read_pointer_gray,
    output write_address, write_enable, write_pointer_gray, level, full, almost_full, overflow
  );
endinterface

// File: rtl/cdc_fifo_write_pointer.sv
// Write-domain pointer/flag engine of the async FIFO: wrap-bit pointer, read-pointer synchroniser, level and flags.
// Optional almost_full comparator enabled by defining CDC_FIFO_WRITE_ALMOST_FULL_EN.
module cdc_fifo_write_pointer #(
  parameter int unsigned ADDRESS_WIDTH         = 4,
  parameter int unsigned SYNC_STAGES           = 2,
  parameter int unsigned ALMOST_FULL_THRESHOLD = (1 << ADDRESS_WIDTH) - 2
) (
  input logic                     clock,
  input logic                     reset,
  cdc_fifo_write_pointer_if.slave bus
);
  localparam int unsigned PW = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_P = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic [ADDRESS_WIDTH:0] r_wptr_bin;
  logic [ADDRESS_WIDTH:0] r_wptr_gray;
  logic [ADDRESS_WIDTH:0] r_sync [SYNC_STAGES];
  logic                   r_overflow;
  logic [ADDRESS_WIDTH:0] w_wptr_next;
  logic [ADDRESS_WIDTH:0] w_rptr_sync;
  logic [ADDRESS_WIDTH:0] w_level;
  logic                   w_full;
  logic                   w_we;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_fifo_write_pointer: SYNC_STAGES must be >= 2");
  end

  // Gray-to-binary: each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_rptr_sync = r_sync[SYNC_STAGES-1];
    for (int unsigned i = 1; i < PW; i++) begin
      w_rptr_sync = w_rptr_sync ^ (r_sync[SYNC_STAGES-1] >> i);
    end
  end

  always_comb begin
    w_level     = r_wptr_bin - w_rptr_sync;
    w_full      = (w_level == DEPTH_P);
    w_we        = bus.increment & ~w_full & ~reset;
    w_wptr_next = r_wptr_bin + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr_bin  <= '0;
      r_wptr_gray <= '0;
      r_overflow  <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      if (w_we) begin
        r_wptr_bin  <= w_wptr_next;
        r_wptr_gray <= w_wptr_next ^ (w_wptr_next >> 1);
      end
      // Set has priority over clear so an overflow on the clearing edge is not lost.
      if (bus.increment && w_full) begin
        r_overflow <= 1'b1;
      end else if (bus.clear_overflow) begin
        r_overflow <= 1'b0;
      end
      r_sync[0] <= bus.read_pointer_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign bus.write_address      = r_wptr_bin[ADDRESS_WIDTH-1:0];
  assign bus.write_enable       = w_we;
  assign bus.write_pointer_gray = r_wptr_gray;
  assign bus.level              = w_level;
  assign bus.full               = w_full;
  assign bus.overflow           = r_overflow;

`ifdef CDC_FIFO_WRITE_ALMOST_FULL_EN
  if (ALMOST_FULL_THRESHOLD < 1 || ALMOST_FULL_THRESHOLD > (1 << ADDRESS_WIDTH)) begin : g_bad_threshold
    $error("cdc_fifo_write_pointer: ALMOST_FULL_THRESHOLD must be in 1..DEPTH");
  end
  assign bus.almost_full = (w_level >= PW'(ALMOST_FULL_THRESHOLD));
`else
  assign bus.almost_full = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_fifo_write_pointer.sv
// Self-checking bench for cdc_fifo_write_pointer (DEPTH=8, 2 sync stages, threshold 6) against an occupancy model.
module tb_cdc_fifo_write_pointer;
  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cdc_fifo_write_pointer_if #(.ADDRESS_WIDTH(3)) bif ();

  cdc_fifo_write_pointer #(
    .ADDRESS_WIDTH(3),
    .SYNC_STAGES(2),
    .ALMOST_FULL_THRESHOLD(6)
  ) dut (
    .clock(clock),
    .reset(rst),
    .bus(bif.slave)
  );

  always #5 clock = ~clock;

  // Reference model: write count mod 16, read-pointer input history (visible after two edges), sticky flag.
  int   m_wptr = 0;
  int   m_rd   = 0;
  bit   m_ovf  = 0;
  logic [3:0] m_hist [2] = '{4'd0, 4'd0};

  function automatic int gray_of(int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int bin_of_gray(logic [3:0] g);
    for (int b = 0; b < 16; b++) if (gray_of(b) == int'(g)) return b;
    return 0;
  endfunction

  function automatic int m_level();
    return (m_wptr - bin_of_gray(m_hist[1]) + 16) % 16;
  endfunction

  function automatic bit m_af();
`ifdef CDC_FIFO_WRITE_ALMOST_FULL_EN
    return m_level() >= 6;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_we();
    return bif.increment && (m_level() != 8) && !rst;
  endfunction

  task automatic step();
    bit full_now;
    bit we_now;
    full_now = (m_level() == 8);
    we_now   = m_we();
    @(posedge clock);
    if (rst) begin
      m_wptr = 0; m_ovf = 0; m_hist[0] = '0; m_hist[1] = '0;
    end else begin
      if (we_now) m_wptr = (m_wptr + 1) % 16;
      if (bif.increment && full_now) m_ovf = 1;
      else if (bif.clear_overflow) m_ovf = 0;
      m_hist[1] = m_hist[0];
      m_hist[0] = bif.read_pointer_gray;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bif.increment = 1'b1; bif.clear_overflow = 1'b0; bif.read_pointer_gray = '0;
    for (int c = 0; c < 2; c++) begin
      #1; total++;
      if (bif.write_enable !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bif.write_enable); end
      step();
      total++;
      if ({bif.write_address, bif.write_pointer_gray, bif.level, bif.full, bif.almost_full, bif.overflow} !== '0) begin
        bad++; $display("FAIL reset_outputs: addr=%0d gray=%b level=%0d full=%b af=%b ovf=%b want all 0",
                        bif.write_address, bif.write_pointer_gray, bif.level, bif.full, bif.almost_full, bif.overflow);
      end
    end
    rst = 1'b0; bif.increment = 1'b0;
    step();
    total++;
    if ({bif.write_address, bif.write_pointer_gray, bif.level, bif.full, bif.almost_full, bif.overflow} !== '0) begin
      bad++; $display("FAIL post_reset_outputs: gray=%b level=%0d want 0", bif.write_pointer_gray, bif.level);
    end
  endtask

  task automatic test_fill_overflow();
    for (int c = 0; c < 8; c++) begin
      bif.increment = 1'b1;
      #1; total++;
      if (bif.write_enable !== m_we()) begin bad++; $display("FAIL fill_we: got %b want %b", bif.write_enable, m_we()); end
      step();
      total++;
      if (bif.write_address !== 3'(m_wptr % 8)) begin
        bad++; $display("FAIL fill_addr: got %0d want %0d", bif.write_address, m_wptr % 8);
      end
    end
    total++;
    if (bif.write_pointer_gray !== 4'b1100 || bif.level !== 4'd8 || bif.full !== 1'b1) begin
      bad++; $display("FAIL fill_full: gray=%b level=%0d full=%b want 1100/8/1", bif.write_pointer_gray, bif.level, bif.full);
    end
    #1; total++;
    if (bif.write_enable !== 1'b0) begin bad++; $display("FAIL full_we: got %b want 0", bif.write_enable); end
    step();
    total++;
    if (bif.write_pointer_gray !== 4'b1100 || bif.overflow !== 1'b1) begin
      bad++; $display("FAIL overflow_set: gray=%b ovf=%b want 1100/1", bif.write_pointer_gray, bif.overflow);
    end
    bif.clear_overflow = 1'b1;
    step();
    total++;
    if (bif.overflow !== 1'b1) begin bad++; $display("FAIL overflow_set_wins: got %b want 1", bif.overflow); end
    bif.increment = 1'b0;
    step();
    bif.clear_overflow = 1'b0;
    total++;
    if (bif.overflow !== m_ovf || bif.overflow !== 1'b0) begin
      bad++; $display("FAIL overflow_clear: got %b want 0", bif.overflow);
    end
  endtask

  task automatic test_sync_latency();
    bif.read_pointer_gray = 4'b0010;
    m_rd = 3;
    step();
    total++;
    if (bif.level !== 4'd8 || bif.full !== 1'b1) begin
      bad++; $display("FAIL sync_edge1: level=%0d full=%b want 8/1", bif.level, bif.full);
    end
    step();
    total++;
    if (bif.level !== 4'd5 || bif.full !== 1'b0 || bif.level !== 4'(m_level())) begin
      bad++; $display("FAIL sync_edge2: level=%0d full=%b want 5/0", bif.level, bif.full);
    end
  endtask

  task automatic test_almost_full();
    total++;
    if (bif.almost_full !== 1'b0) begin bad++; $display("FAIL af_below: got %b want 0", bif.almost_full); end
    bif.increment = 1'b1;
    step();
    bif.increment = 1'b0;
    total++;
    if (bif.level !== 4'd6 || bif.almost_full !== m_af()) begin
      bad++; $display("FAIL af_rise: level=%0d af=%b want 6/%b", bif.level, bif.almost_full, m_af());
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    prev = bif.write_pointer_gray;
    for (int c = 0; c < 24; c++) begin
      bif.increment = 1'b1;
      m_rd = (m_rd + 1) % 16;
      bif.read_pointer_gray = 4'(gray_of(m_rd));
      step();
      total++;
      if (bif.write_pointer_gray !== 4'(gray_of(m_wptr)) || bif.write_address !== 3'(m_wptr % 8) ||
          bif.level !== 4'(m_level()) || $countones(bif.write_pointer_gray ^ prev) != 1) begin
        bad++; $display("FAIL wrap_walk: gray=%b prev=%b addr=%0d level=%0d want gray=%b addr=%0d level=%0d",
                        bif.write_pointer_gray, prev, bif.write_address, bif.level, 4'(gray_of(m_wptr)), m_wptr % 8, m_level());
      end
      prev = bif.write_pointer_gray;
    end
    bif.increment = 1'b0;
  endtask

  task automatic test_reset_mid_and_random();
    rst = 1'b1; bif.read_pointer_gray = '0; m_rd = 0;
    step();
    rst = 1'b0; bif.increment = 1'b1;
    for (int c = 0; c < 4; c++) step();
    total++;
    if (bif.level !== 4'd4) begin bad++; $display("FAIL pre_reset_level: got %0d want 4", bif.level); end
    rst = 1'b1;
    step();
    total++;
    if ({bif.write_address, bif.write_pointer_gray, bif.level, bif.full, bif.almost_full, bif.overflow} !== '0) begin
      bad++; $display("FAIL mid_reset: gray=%b level=%0d want 0", bif.write_pointer_gray, bif.level);
    end
    rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bif.increment      = ($urandom_range(0, 3) != 0);
      bif.clear_overflow = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0 && m_rd != m_wptr) m_rd = (m_rd + 1) % 16;
      bif.read_pointer_gray = 4'(gray_of(m_rd));
      #1; total++;
      if (bif.write_enable !== m_we()) begin bad++; $display("FAIL rand_we: got %b want %b", bif.write_enable, m_we()); end
      step();
      total++;
      if (bif.level !== 4'(m_level()) || bif.full !== (m_level() == 8) || bif.almost_full !== m_af() ||
          bif.overflow !== m_ovf || bif.write_pointer_gray !== 4'(gray_of(m_wptr)) || bif.write_address !== 3'(m_wptr % 8)) begin
        bad++; $display("FAIL rand_state: level=%0d full=%b af=%b ovf=%b gray=%b want level=%0d af=%b ovf=%b gray=%b",
                        bif.level, bif.full, bif.almost_full, bif.overflow, bif.write_pointer_gray,
                        m_level(), m_af(), m_ovf, 4'(gray_of(m_wptr)));
      end
    end
  endtask

  initial begin
    bif.increment = 1'b0; bif.clear_overflow = 1'b0; bif.read_pointer_gray = '0;
    #1;
    test_reset();
    test_fill_overflow();
    test_sync_latency();
    test_almost_full();
    test_wrap();
    test_reset_mid_and_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
